// File: rtl/maxpool_pkg.sv
// Shared definitions for the stream demultiplexer: width/row defaults and channel encodings.
package maxpool_pkg;

    localparam int DATA_WIDHT_DEF = 8;
    localparam int ROW_LEN_DEF    = 4;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } channel_e;

endpackage : maxpool_pkg

// File: rtl/demux_stream_out_slot.sv
// One-entry output register slice: accepts a word on load, presents it until the sink drains it.
module out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);

    // Free when empty, or when the current word leaves on this edge.
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule : out_slot

// File: rtl/demux_stream.sv
// Two-way stream demultiplexer with per-channel one-entry output slots.
// Build macro DEMUX_AUTO_SEL_EN: channel chosen by an internal row counter instead of Select.
module demux_stream
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDHT = DATA_WIDHT_DEF,
    parameter int ROW_LEN    = ROW_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic                  Select,
    output logic [DATA_WIDHT-1:0] Data_A,
    output logic                  A_Valid,
    input  logic                  A_Ready,
    output logic [DATA_WIDHT-1:0] Data_B,
    output logic                  B_Valid,
    input  logic                  B_Ready,
    output logic                  Sel_State
);

    channel_e eff_ch;
    logic     a_free;
    logic     b_free;
    logic     xfer;
    logic     load_a;
    logic     load_b;

`ifdef DEMUX_AUTO_SEL_EN
    channel_e   sel_q;
    logic [7:0] beat_cnt;
    logic       unused_select;

    assign unused_select = Select;

    // Counter and select only move on an accepted beat, so stalls freeze the row position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            sel_q    <= CH_A;
        end else if (xfer) begin
            if (beat_cnt == 8'(ROW_LEN - 1)) begin
                beat_cnt <= '0;
                sel_q    <= (sel_q == CH_A) ? CH_B : CH_A;
            end else begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    assign eff_ch = sel_q;
`else
    assign eff_ch = channel_e'(Select);
`endif

    assign Sel_State = logic'(eff_ch);

    always_comb begin
        In_Ready = 1'b0;
        if (rst_n) begin
            In_Ready = (eff_ch == CH_A) ? a_free : b_free;
        end
    end

    assign xfer   = In_Valid && In_Ready;
    assign load_a = xfer && (eff_ch == CH_A);
    assign load_b = xfer && (eff_ch == CH_B);

    out_slot #(.WIDTH(DATA_WIDHT)) u_slot_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_a),
        .data_in (Data_In),
        .ready   (A_Ready),
        .data    (Data_A),
        .valid   (A_Valid),
        .free    (a_free)
    );

    out_slot #(.WIDTH(DATA_WIDHT)) u_slot_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_b),
        .data_in (Data_In),
        .ready   (B_Ready),
        .data    (Data_B),
        .valid   (B_Valid),
        .free    (b_free)
    );

endmodule : demux_stream

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter DATA_WIDHT, default 8, is the data word width in bits.
REQ-002 Parameter ROW_LEN, default 4, is the beats per row before the auto-select toggles; legal range 1..255.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port Data_In, input, DATA_WIDHT: the input word.
REQ-006 Port In_Valid, input, 1: Data_In is valid.
REQ-007 Port In_Ready, output, 1: the block accepts Data_In this cycle.
REQ-008 Port Select, input, 1: channel for the current beat (0=A, 1=B); used only when DEMUX_AUTO_SEL_EN is undefined.
REQ-009 Port Data_A / A_Valid, output, DATA_WIDHT / 1: channel A word and valid.
REQ-010 Port A_Ready, input, 1: the channel A sink accepts.
REQ-011 Port Data_B / B_Valid, output, DATA_WIDHT / 1: channel B word and valid.
REQ-012 Port B_Ready, input, 1: the channel B sink accepts.
REQ-013 Port Sel_State, output, 1: the effective channel for the next accepted beat.

Function
REQ-014 An input transfer occurs when In_Valid && In_Ready; an output transfer occurs when X_Valid && X_Ready.
REQ-015 Each channel holds a one-entry output slot (data register plus valid flag).
REQ-016 In_Ready shall be 1 when the slot of the effective channel is empty, or is full and drains in the same cycle; it is combinational from slot state and the sink ready.
REQ-017 An accepted word is written to the selected slot, and X_Valid becomes 1 on the next edge; latency is 1 cycle.
REQ-018 Data_X stays stable while X_Valid && !X_Ready.
REQ-019 When a slot drains with no refill, X_Valid goes to 0 on the next edge, and Data_X holds its last value.
REQ-020 When a slot drains and refills in the same cycle, X_Valid stays 1 and Data_X takes the new word.
REQ-021 The unselected channel's slot is never modified by an input transfer; both channels drain independently and concurrently.
REQ-022 Per-channel order is preserved; a word is never dropped or duplicated.
REQ-023 When the effective channel is full and not draining, In_Ready is 0, and no counter or select state advances.
REQ-024 No output is combinationally dependent on Data_In.

Reset
REQ-025 On rst_n=0, asynchronously: A_Valid=0, B_Valid=0, Data_A=0, Data_B=0, beat counter=0, select state=0 (channel A).
REQ-026 When reset is asserted mid-transfer, the in-flight words are discarded; after deassertion the first accepted beat follows REQ-025 state.
REQ-027 In_Ready is 0 while rst_n=0.

Configuration
REQ-028 The macro DEMUX_AUTO_SEL_EN enables the auto-select feature.
REQ-029 With DEMUX_AUTO_SEL_EN defined: the Select input is ignored; an internal 8-bit beat counter increments on each input transfer; when it reaches ROW_LEN-1 and a transfer occurs, it wraps to 0 and the select state toggles on the same edge.
REQ-030 With DEMUX_AUTO_SEL_EN defined: Sel_State equals the select state.
REQ-031 With DEMUX_AUTO_SEL_EN defined and ROW_LEN=1: the select toggles on every beat.
REQ-032 With DEMUX_AUTO_SEL_EN undefined: the counter and select register are not built; the effective channel = Select, sampled in the transfer cycle; Sel_State = Select.

Structure
REQ-033 Shared package maxpool_pkg holds the DATA_WIDHT default, the channel encodings CH_A=1'b0 and CH_B=1'b1, and the ROW_LEN default.
REQ-034 One sub-module, out_slot (one-entry register slice with load/drain/valid), is instantiated twice (channels A and B).

Verification
REQ-035 Manual mode, both sinks ready, input 0x11/Sel0, 0x22/Sel1, 0x33/Sel0 back-to-back -> A gets 0x11 then 0x33, B gets 0x22, each 1 cycle after acceptance, and In_Ready stays 1.
REQ-036 A_Ready=0, input 0x44 then 0x55 to A -> 0x44 held on Data_A with In_Ready=0 for the second beat; after A_Ready=1, 0x55 follows with no loss.
REQ-037 A full and stalled, input 0x66 to B -> B accepts 0x66 and outputs it while A still holds its word.
REQ-038 Auto mode, ROW_LEN=4, 8 beats 0x01..0x08, sinks ready -> 0x01..0x04 on A, 0x05..0x08 on B, and Sel_State returns to 0 after beat 8.
REQ-039 Auto mode, stall on beat 3 for 5 cycles -> the counter does not advance and the toggle still occurs after the 4th accepted beat.
REQ-040 Assert rst_n=0 while A_Valid=1 and the counter is at 2 -> all valids and data go to 0 immediately and the counter and select go to 0; the next beat goes to A.
